// File: rtl/regfile_dump_reader.sv
// Walks a register-file address range over a spare read port and streams
// {address, data} snapshots out through a valid/ready handshake.
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | raddr presented, capture rdata on this edge
    // SEND  | word held on out_* until handshake
    // FIN   | done pulse, return to IDLE
    typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_q    <= '0;
            raddr     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            last_q <= last_addr;
                            raddr  <= first_addr;
                            busy   <= 1'b1;
                            state  <= READ;
                        end
                    end
                    READ: begin
                        // Hardwired-zero register is stepped over without a transfer
                        if (SKIP_ZERO && raddr == '0) begin
                            if (raddr == last_q) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                raddr <= raddr + 1'b1;
                            end
                        end else begin
                            out_data  <= rdata;
                            out_addr  <= raddr;
                            out_valid <= 1'b1;
                            state     <= SEND;
                        end
                    end
                    SEND: begin
                        if (out_ready) begin
                            out_valid <= 1'b0;
                            if (out_addr == last_q) begin
                                state <= FIN;
                                done  <= 1'b1;
                            end else begin
                                raddr <= raddr + 1'b1;
                                state <= READ;
                            end
                        end
                    end
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: two instances (SKIP_ZERO 0 and 1)
// share a modelled register file; expected words are queued at start time.
module tb_regfile_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, start0, start1, abort, out_ready, sel;
    logic [AW-1:0] first_addr, last_addr;
    logic [AW-1:0] raddr0, raddr1, oa0, oa1, oa_m;
    logic [DW-1:0] rdata0, rdata1, od0, od1, od_m;
    logic          ov0, ov1, busy0, busy1, done0, done1, v_m, busy_m, done_m;
    logic [DW-1:0] rf [32];

    int            checks = 0, failures = 0, done_cnt = 0, words_seen = 0;
    logic [36:0]   exp_q[$];
    logic [36:0]   exp_e;

    always #5 clk = ~clk;

    assign rdata0 = rf[raddr0];
    assign rdata1 = rf[raddr1];
    assign v_m    = sel ? ov1 : ov0;
    assign oa_m   = sel ? oa1 : oa0;
    assign od_m   = sel ? od1 : od0;
    assign busy_m = sel ? busy1 : busy0;
    assign done_m = sel ? done1 : done0;

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr), .raddr(raddr0), .rdata(rdata0),
        .out_valid(ov0), .out_ready(out_ready), .out_addr(oa0), .out_data(od0),
        .busy(busy0), .done(done0));

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort),
        .first_addr(first_addr), .last_addr(last_addr), .raddr(raddr1), .rdata(rdata1),
        .out_valid(ov1), .out_ready(out_ready), .out_addr(oa1), .out_data(od1),
        .busy(busy1), .done(done1));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [4:0] f, input logic [4:0] l, input bit skip);
        int n;
        logic [4:0] a;
        n = ((int'(l) - int'(f)) & 31) + 1;
        for (int i = 0; i < n; i++) begin
            a = 5'((int'(f) + i) & 31);
            if (!(skip && a == 5'd0)) exp_q.push_back({a, rf[a]});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after start.
    task automatic start_dump(input bit s, input logic [4:0] f, input logic [4:0] l);
        sel        = s;
        first_addr = f;
        last_addr  = l;
        push_range(f, l, s);
        if (s) start1 = 1'b1;
        else   start0 = 1'b1;
        next_cycle();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy_m) break;
        end
        chk("idle_timeout", 64'(busy_m), 64'd0);
        next_cycle();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (v_m && out_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(oa_m), 64'h1_0000_0000);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("word_addr", 64'(oa_m), 64'(exp_e[36:32]));
                    chk("word_data", 64'(od_m), 64'(exp_e[31:0]));
                end
            end
            if (done_m) begin
                done_cnt++;
                chk("done_valid_excl", 64'(v_m), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int d0, w0;
        bit exp_v, exp_b;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
        out_ready = 1'b1; sel = 1'b0; first_addr = '0; last_addr = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
        rf[0] = 32'h0;

        #12;
        chk("rst_valid", 64'(ov0 | ov1), 64'd0);
        chk("rst_busy", 64'(busy0 | busy1), 64'd0);
        chk("rst_outs", 64'(oa0 | raddr0 | od0), 64'd0);
        #11 rst = 1'b0;
        next_cycle();

        // Basic range with exact cycle timing
        start_dump(1'b0, 5'd3, 5'd5);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) next_cycle();
            @(negedge clk);
            exp_v = (k == 2 || k == 4 || k == 6);
            exp_b = (k <= 7);
            chk($sformatf("t1_valid_c%0d", k), 64'(v_m), 64'(exp_v));
            chk($sformatf("t1_done_c%0d", k), 64'(done_m), 64'(k == 7));
            chk($sformatf("t1_busy_c%0d", k), 64'(busy_m), 64'(exp_b));
        end
        chk("t1_q_empty", 64'(exp_q.size()), 64'd0);
        next_cycle();

        // Wrapping range with register 0 skipped
        d0 = done_cnt;
        start_dump(1'b1, 5'd30, 5'd1);
        wait_idle();
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // Single word with backpressure
        sel = 1'b0;
        out_ready = 1'b0;
        start_dump(1'b0, 5'd7, 5'd7);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_valid", 64'(v_m), 64'd1);
            chk("t3_hold_data", 64'(od_m), 64'h1000_0007);
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("t3_done_after_accept", 64'(done_m), 64'd1);
        wait_idle();
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Full 32-register dump, random backpressure, ignored start while busy
        w0 = words_seen;
        start_dump(1'b0, 5'd1, 5'd0);
        for (int c = 0; c < 400; c++) begin
            if (c == 8) begin
                start0 = 1'b1; first_addr = 5'd20; last_addr = 5'd25;
            end else begin
                start0 = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy_m) break;
            next_cycle();
        end
        start0 = 1'b0;
        out_ready = 1'b1;
        chk("t4_finished", 64'(busy_m), 64'd0);
        chk("t4_word_count", 64'(words_seen - w0), 64'd32);
        chk("t4_q_empty", 64'(exp_q.size()), 64'd0);
        next_cycle();

        // Abort during the third SEND of a 0..9 dump
        d0 = done_cnt;
        sel = 1'b0; first_addr = 5'd0; last_addr = 5'd9;
        exp_q.push_back({5'd0, rf[0]});
        exp_q.push_back({5'd1, rf[1]});
        start0 = 1'b1;
        next_cycle();
        start0 = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            if (c == 5) out_ready = 1'b0;
        end
        next_cycle();
        abort = 1'b1;
        @(negedge clk);
        chk("t5_third_valid", 64'(v_m), 64'd1);
        chk("t5_third_addr", 64'(oa_m), 64'd2);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("t5_abort_valid", 64'(v_m), 64'd0);
        chk("t5_abort_busy", 64'(busy_m), 64'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
        chk("t5_q_empty", 64'(exp_q.size()), 64'd0);
        next_cycle();
        out_ready = 1'b1;
        start_dump(1'b0, 5'd5, 5'd6);
        wait_idle();
        chk("t5_restart_q_empty", 64'(exp_q.size()), 64'd0);

        // start with abort in IDLE stays idle
        abort = 1'b1; start0 = 1'b1;
        next_cycle();
        abort = 1'b0; start0 = 1'b0;
        @(negedge clk);
        chk("t6_abort_wins", 64'(busy_m), 64'd0);
        next_cycle();

        // Asynchronous reset mid-dump
        out_ready = 1'b0;
        start_dump(1'b0, 5'd10, 5'd12);
        repeat (3) next_cycle();
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_valid", 64'(ov0), 64'd0);
        chk("t7_rst_busy", 64'(busy0), 64'd0);
        chk("t7_rst_data", 64'(od0), 64'd0);
        chk("t7_rst_addr", 64'({oa0, raddr0}), 64'd0);
        chk("t7_rst_done", 64'(done0), 64'd0);
        exp_q.delete();
        #3 rst = 1'b0;
        next_cycle();

        // Later write does not disturb an emitted word
        start_dump(1'b0, 5'd4, 5'd4);
        next_cycle();
        rf[4] = 32'hDEAD_BEEF;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("t8_snapshot", 64'(od_m), 64'h1000_0004);
        out_ready = 1'b1;
        wait_idle();
        rf[4] = 32'h1000_0004;
        chk("t8_q_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
